// File: rtl/pol_coeff_packer.sv
// ============================================================================
// Module   : pol_coeff_packer
// Purpose  : Streaming packer that accepts COEFF_W-bit polynomial
//            coefficients one per cycle and writes them as little-endian
//            packed 64-bit words into the polynomial BRAM. With the default
//            parameters, 256 x 13-bit coefficients make 3328 bits, which is
//            52 words at relative addresses 0..51.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   1        clock, rising edge
//   rst_n        in   1        synchronous active-low reset
//   start        in   1        one-cycle pulse, begins one polynomial
//   coeff_in     in   COEFF_W  coefficient data
//   coeff_valid  in   1        coeff_in valid this cycle
//   coeff_ready  out  1        block accepts a coefficient this cycle
//   wr_en        out  1        BRAM write strobe
//   wr_addr      out  7        relative word address
//   wr_data      out  64       packed word
//   done         out  1        one-cycle pulse with the final word write
//   checksum     out  64       running XOR of the words written
//
// Build option:
//   PACK_CHECKSUM_EN  When defined, a checksum register is built and
//                     accumulates the XOR of every word written. It is
//                     cleared on start. When undefined, checksum is tied to 0.
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pol_coeff_packer #(
  parameter int COEFF_W = 13,
  parameter int N_COEFF = 256,
  parameter int N_WORD  = 52
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COEFF_W-1:0] coeff_in,
  input  logic               coeff_valid,
  output logic               coeff_ready,
  output logic               wr_en,
  output logic [6:0]         wr_addr,
  output logic [63:0]        wr_data,
  output logic               done,
  output logic [63:0]        checksum
);

  // The accumulator must hold a nearly full word (fill up to 63) plus one
  // more coefficient.
  localparam int ACC_W  = 64 + COEFF_W - 1;
  localparam int CNT_W  = $clog2(N_COEFF);
  localparam int FILL_W = 6;
  localparam int SUM_W  = 7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PACK = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   coeff_cnt;
  logic [6:0]         word_cnt;
  logic [ACC_W-1:0]   acc;
  logic [FILL_W-1:0]  fill;

  logic               accept;
  logic [ACC_W-1:0]   merged;
  logic [SUM_W-1:0]   fill_sum;
  logic               word_full;
  logic               last_coeff;
  logic               last_word;

  // coeff_ready is a registered copy of (state == PACK).
  assign accept     = coeff_valid && coeff_ready;
  assign merged     = acc | (ACC_W'(coeff_in) << fill);
  assign fill_sum   = SUM_W'(fill) + SUM_W'(COEFF_W);
  // fill_sum never exceeds 63 + COEFF_W < 128, so bit 6 alone says
  // "a full word is available", and the low 6 bits are already the
  // post-emission fill (subtracting 64 only clears bit 6).
  assign word_full  = fill_sum[6];
  assign last_coeff = (coeff_cnt == CNT_W'(N_COEFF - 1));
  assign last_word  = (word_cnt == 7'(N_WORD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      coeff_ready <= 1'b0;
      coeff_cnt   <= '0;
      word_cnt    <= '0;
      acc         <= '0;
      fill        <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      done        <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      wr_en <= 1'b0;
      done  <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state       <= PACK;
            coeff_ready <= 1'b1;
            coeff_cnt   <= '0;
            word_cnt    <= '0;
            acc         <= '0;
            fill        <= '0;
          end
        end

        PACK: begin
          // start is deliberately ignored here; only accepted
          // coefficients move the datapath.
          if (accept) begin
            coeff_cnt <= coeff_cnt + CNT_W'(1);
            fill      <= fill_sum[FILL_W-1:0];

            if (word_full) begin
              acc      <= merged >> 64;
              wr_en    <= 1'b1;
              wr_addr  <= word_cnt;
              wr_data  <= merged[63:0];
              done     <= last_word;
              word_cnt <= word_cnt + 7'd1;
            end else begin
              acc <= merged;
            end

            if (last_coeff) begin
              state       <= IDLE;
              coeff_ready <= 1'b0;
            end
          end
        end

        default: begin
          state       <= IDLE;
          coeff_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef PACK_CHECKSUM_EN
  logic [63:0] csum;

  // Updated on the same edge that launches each word, so the value seen
  // alongside the final wr_en/done already includes the last word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (state == IDLE && start) begin
      csum <= '0;
    end else if (state == PACK && accept && word_full) begin
      csum <= csum ^ merged[63:0];
    end
  end

  assign checksum = csum;
`else
  assign checksum = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pol_coeff_packer.sv
// ============================================================================
// Module   : tb_pol_coeff_packer
// Purpose  : Scoreboard testbench for pol_coeff_packer. Stimulus pushes the
//            expected word writes into a queue; a monitor pops and compares
//            whenever the DUT strobes wr_en.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pol_coeff_packer;

  localparam int COEFF_W = 13;
  localparam int N_COEFF = 256;
  localparam int N_WORD  = 52;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [COEFF_W-1:0] coeff_in = '0;
  logic               coeff_valid = 1'b0;
  logic               coeff_ready;
  logic               wr_en;
  logic [6:0]         wr_addr;
  logic [63:0]        wr_data;
  logic               done;
  logic [63:0]        checksum;

  always #5 clk = ~clk;

  pol_coeff_packer #(
    .COEFF_W(COEFF_W),
    .N_COEFF(N_COEFF),
    .N_WORD (N_WORD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .coeff_in   (coeff_in),
    .coeff_valid(coeff_valid),
    .coeff_ready(coeff_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .done       (done),
    .checksum   (checksum)
  );

  typedef struct packed {
    logic [6:0]  addr;
    logic [63:0] data;
    logic        last;
    logic [63:0] cs;
  } exp_t;

  exp_t               exp_q[$];
  exp_t               mon_e;
  int                 n_checks = 0;
  int                 n_fail   = 0;
  logic [COEFF_W-1:0] coef [N_COEFF];
  logic [63:0]        got  [N_WORD];
  int                 cyc       = 0;
  int                 done_cyc  = -1;
  int                 start_cyc = 0;
  bit                 last_accept = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every write must follow an accepting edge and match the queue head.
  always @(negedge clk) begin
    if (wr_en) begin
      check64("write_after_accept", 64'(last_accept), 64'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: actual addr %0d data %h, required no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check64("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
        check64("wr_data", wr_data, mon_e.data);
        check64("done_flag", 64'(done), 64'(mon_e.last));
        check64("checksum", checksum, mon_e.cs);
        if (wr_addr < 7'(N_WORD)) got[wr_addr] = wr_data;
      end
      if (done) done_cyc = cyc;
    end else if (done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_without_write: actual done=1 wr_en=0, required done=0");
    end
    last_accept = rst_n && coeff_valid && coeff_ready;
  end

  // Reference: lay coefficients into one flat little-endian stream, slice words.
  task automatic push_expected(input int n_words);
    logic [N_COEFF*COEFF_W-1:0] stream;
    logic [63:0]                cs;
    logic [63:0]                d;
    exp_t                       e;
    stream = '0;
    for (int i = 0; i < N_COEFF; i++) stream[i*COEFF_W +: COEFF_W] = coef[i];
    cs = '0;
    for (int w = 0; w < n_words; w++) begin
      d = stream[w*64 +: 64];
`ifdef PACK_CHECKSUM_EN
      cs = cs ^ d;
`endif
      e.addr = 7'(w);
      e.data = d;
      e.last = (w == N_WORD - 1);
      e.cs   = cs;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_poly(input int n_acc, input bit rand_valid, input int start_at);
    int i;
    int guard;
    bit ok;
    start_cyc = cyc;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    i = 0;
    guard = 0;
    while (i < n_acc && guard < 5000) begin
      coeff_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      coeff_in    = coef[i];
      start       = (i == start_at);
      ok          = coeff_valid && coeff_ready;
      @(posedge clk); #2;
      if (ok) i++;
      guard++;
    end
    coeff_valid = 1'b0;
    start       = 1'b0;
    check64("coeffs_accepted", 64'(i), 64'(n_acc));
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(posedge clk); #2;
      k++;
    end
    check64("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check64({tag, "_coeff_ready"}, 64'(coeff_ready), 64'd0);
    check64({tag, "_wr_en"},       64'(wr_en),       64'd0);
    check64({tag, "_wr_addr"},     64'(wr_addr),     64'd0);
    check64({tag, "_wr_data"},     wr_data,          64'd0);
    check64({tag, "_done"},        64'(done),        64'd0);
    check64({tag, "_checksum"},    checksum,         64'd0);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #2;

    // coeff_valid in IDLE is ignored
    coeff_valid = 1'b1;
    coeff_in    = 13'h1FFF;
    repeat (5) begin
      @(posedge clk); #2;
      check64("idle_ready_low", 64'(coeff_ready), 64'd0);
    end
    coeff_valid = 1'b0;
    check64("idle_wr_addr", 64'(wr_addr), 64'd0);

    // All ones, continuous: every word all ones, done 257 cycles after start cycle
    for (int i = 0; i < N_COEFF; i++) coef[i] = 13'h1FFF;
    push_expected(N_WORD);
    done_cyc = -1;
    run_poly(N_COEFF, 1'b0, -1);
    wait_drain();
    check64("latency_start_to_done", 64'(done_cyc - start_cyc), 64'd257);
    check64("ones_checksum", checksum, 64'd0);

    // Ramp i = i
    for (int i = 0; i < N_COEFF; i++) coef[i] = 13'(i);
    push_expected(N_WORD);
    run_poly(N_COEFF, 1'b0, -1);
    wait_drain();
    check64("ramp_word0", got[0], 64'h0040_0180_0800_2000);

    // Word boundary split: c4 = 0x1000 lands in bit 0 of word 1
    for (int i = 0; i < N_COEFF; i++) coef[i] = '0;
    coef[4] = 13'h1000;
    push_expected(N_WORD);
    run_poly(N_COEFF, 1'b0, -1);
    wait_drain();
    check64("split_word0", got[0], 64'h0);
    check64("split_word1", got[1], 64'h1);
    repeat (4) @(posedge clk);
    #2;
`ifdef PACK_CHECKSUM_EN
    check64("split_checksum_hold", checksum, 64'h1);
`else
    check64("split_checksum_hold", checksum, 64'h0);
`endif

    // Ramp with random 50% valid gaps
    for (int i = 0; i < N_COEFF; i++) coef[i] = 13'(i);
    push_expected(N_WORD);
    run_poly(N_COEFF, 1'b1, -1);
    wait_drain();

    // Reset after 100 coefficients: words 0..19 are written, nothing more
    for (int i = 0; i < N_COEFF; i++) coef[i] = 13'((i * 37 + 5) % 8192);
    push_expected(20);
    run_poly(100, 1'b0, -1);
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    check_reset_outputs("midreset");
    repeat (10) @(posedge clk);
    #2;
    wait_drain();
    check64("midreset_ready_low", 64'(coeff_ready), 64'd0);
    push_expected(N_WORD);
    run_poly(N_COEFF, 1'b0, -1);
    wait_drain();

    // start pulsed mid-PACK is ignored
    for (int i = 0; i < N_COEFF; i++) coef[i] = 13'(8191 - i);
    push_expected(N_WORD);
    run_poly(N_COEFF, 1'b0, 100);
    wait_drain();
    check64("final_ready_low", 64'(coeff_ready), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout, required test completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
